// File: rtl/rll_keyed_datapath_seq.sv
// Sequential RLL key-gated datapath: serial valid/ready key load, then XOR/XNOR gating into a registered output.
// Optional feature macro RLL_LOAD_LIMIT_EN: limits key loads to MAX_LOADS, then asserts lockout until reset.
module rll_keyed_datapath_seq #(
  parameter int                KEY_W     = 32,
  parameter int                DATA_W    = 32,
  parameter logic [KEY_W-1:0]  POL_MASK  = '0,
  parameter int                MAX_LOADS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              key_bit,
  input  logic              key_valid,
  output logic              key_ready,
  output logic              armed,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              lockout
);

  localparam int CW = $clog2(KEY_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ARMED = 2'd2
  } state_t;

  if (KEY_W < 2 || MAX_LOADS < 1) begin : g_bad_param
    $error("rll_keyed_datapath_seq: KEY_W must be >= 2 and MAX_LOADS >= 1");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [KEY_W-1:0]  r_key;
  logic [CW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_out_valid;
  logic [DATA_W-1:0] w_gated;
  logic              w_clear;
  logic              w_accept;
  logic              w_locked;
  logic              w_limit_hit;

  // ---------------------------------------------------------------------------
  // Optional load limiter
  // ---------------------------------------------------------------------------
`ifdef RLL_LOAD_LIMIT_EN
  localparam int LC_W = $clog2(MAX_LOADS + 1);

  logic [LC_W-1:0] r_load_cnt;
  logic            r_lockout;
  logic            w_count_load;
  logic            w_lock_now;

  // A counted load is a real IDLE/ARMED -> LOAD transition, never a restart inside LOAD.
  assign w_count_load = w_clear && (r_state != S_LOAD) && (w_state_nxt == S_LOAD);
  assign w_lock_now   = w_clear && (w_state_nxt == S_IDLE);
  assign w_locked     = r_lockout;
  assign w_limit_hit  = (r_load_cnt == LC_W'(MAX_LOADS));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_cnt <= '0;
      r_lockout  <= 1'b0;
    end else begin
      if (w_count_load && !w_limit_hit) r_load_cnt <= r_load_cnt + LC_W'(1);
      if (w_lock_now) r_lockout <= 1'b1;
    end
  end

  assign lockout = r_lockout;
`else
  assign w_locked    = 1'b0;
  assign w_limit_hit = 1'b0;
  assign lockout     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: next-state and key-register control
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE, S_ARMED: begin
        if (load_start && !w_locked) begin
          w_clear = 1'b1;
          if (w_limit_hit) w_state_nxt = S_IDLE;
          else             w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_start) begin
          w_clear = 1'b1;
        end else if (key_valid) begin
          w_accept = 1'b1;
          if (r_bit_cnt == CW'(KEY_W - 1)) w_state_nxt = S_ARMED;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_key     <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_key     <= '0;
        r_bit_cnt <= '0;
      end else if (w_accept) begin
        for (int i = 0; i < KEY_W; i++) begin
          if (r_bit_cnt == CW'(i)) r_key[i] <= key_bit;
        end
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end
    end
  end

  assign key_ready = (r_state == S_LOAD);
  assign armed     = (r_state == S_ARMED);

  // ---------------------------------------------------------------------------
  // Key gates and output register
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < DATA_W; i++) begin : g_gate
    localparam int K = i % KEY_W;
    // XNOR is XOR with an inverted output, so the polarity bit folds in as a third XOR term.
    assign w_gated[i] = data_in[i] ^ r_key[K] ^ POL_MASK[K];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
    end else begin
      r_data_out_valid <= armed && data_in_valid;
      if (armed && data_in_valid) r_data_out <= w_gated;
    end
  end

  assign data_out       = r_data_out;
  assign data_out_valid = r_data_out_valid;

endmodule

// File: tb/tb_rll_keyed_datapath_seq.sv
// Directed bench for rll_keyed_datapath_seq at KEY_W=8, DATA_W=8, POL_MASK=8'h0F, MAX_LOADS=2.
// Expected data_out = data_in ^ key ^ 8'h0F, computed by hand in the vector table.
module tb_rll_keyed_datapath_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic       key_bit;
  logic       key_valid;
  logic       key_ready;
  logic       armed;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       lockout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rll_keyed_datapath_seq #(
    .KEY_W    (8),
    .DATA_W   (8),
    .POL_MASK (8'h0F),
    .MAX_LOADS(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load_start    (load_start),
    .key_bit       (key_bit),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .armed         (armed),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .lockout       (lockout)
  );

  typedef struct {
    logic       din_valid;
    logic [7:0] din;
    logic       exp_valid;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; load_start = 1'b0; key_bit = 1'b0; key_valid = 1'b0;
    data_in = 8'h00; data_in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("load_ready", key_ready, 1);
    check("load_armed", armed, 0);
  endtask

  task automatic shift_key(input logic [7:0] k);
    for (int i = 0; i < 8; i++) begin
      key_valid = 1'b1;
      key_bit   = k[i];
      step();
      check($sformatf("armed_after_bit%0d", i), armed, (i == 7) ? 1 : 0);
    end
    key_valid = 1'b0;
  endtask

  task automatic apply_data(input string name, input logic [7:0] din, input logic [7:0] exp);
    data_in_valid = 1'b1;
    data_in       = din;
    step();
    data_in_valid = 1'b0;
    check({name, "_valid"}, data_out_valid, 1);
    check({name, "_data"}, data_out, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 8'h00, 1'b1, 8'hAA};
    vecs[1] = '{1'b1, 8'hFF, 1'b1, 8'h55};
    vecs[2] = '{1'b1, 8'h0F, 1'b1, 8'hA5};
    vecs[3] = '{1'b1, 8'hF0, 1'b1, 8'h5A};
    vecs[4] = '{1'b1, 8'h3C, 1'b1, 8'h96};
    vecs[5] = '{1'b0, 8'h77, 1'b0, 8'h96};

    // T1 reset
    do_reset();
    check("t1_key_ready", key_ready, 0);
    check("t1_armed", armed, 0);
    check("t1_data_out", data_out, 0);
    check("t1_data_out_valid", data_out_valid, 0);
    check("t1_lockout", lockout, 0);
    data_in_valid = 1'b1; data_in = 8'h12;
    step();
    data_in_valid = 1'b0;
    check("t1_idle_no_valid", data_out_valid, 0);

    // T2 load key A5 and run the vector table
    start_load();
    shift_key(8'hA5);
    check("t2_ready_when_armed", key_ready, 0);
    for (int v = 0; v < 6; v++) begin
      data_in_valid = vecs[v].din_valid;
      data_in       = vecs[v].din;
      step();
      check($sformatf("t2_vec%0d_valid", v), data_out_valid, vecs[v].exp_valid);
      check($sformatf("t2_vec%0d_data", v), data_out, vecs[v].exp_out);
    end
    data_in_valid = 1'b0;

    // T3 backpressure gaps, completing bit coincides with data_in_valid
    do_reset();
    start_load();
    for (int i = 0; i < 8; i++) begin
      if (i == 2 || i == 5) begin
        key_valid = 1'b0;
        key_bit   = ~8'hA5 >> i;
        step();
        step();
        check($sformatf("t3_gap_armed%0d", i), armed, 0);
      end
      key_valid = 1'b1;
      key_bit   = 8'hA5 >> i;
      if (i == 7) begin
        data_in_valid = 1'b1;
        data_in       = 8'h00;
      end
      step();
    end
    key_valid = 1'b0;
    data_in_valid = 1'b0;
    check("t3_armed", armed, 1);
    check("t3_last_bit_data_dropped", data_out_valid, 0);
    apply_data("t3_d00", 8'h00, 8'hAA);
    apply_data("t3_dFF", 8'hFF, 8'h55);

    // T4 reload while armed, plus restart inside LOAD
    do_reset();
    start_load();
    shift_key(8'hA5);
    data_in_valid = 1'b1; data_in = 8'hFF; load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("t4_armed_drop", armed, 0);
    check("t4_ready", key_ready, 1);
    check("t4_last_valid", data_out_valid, 1);
    check("t4_last_data", data_out, 8'h55);
    step();
    data_in_valid = 1'b0;
    check("t4_valid_cleared", data_out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      key_valid = 1'b1; key_bit = 1'b1;
      step();
    end
    load_start = 1'b1;
    step();
    load_start = 1'b0; key_valid = 1'b0;
    check("t4_restart_ready", key_ready, 1);
    shift_key(8'h00);
    apply_data("t4_d00", 8'h00, 8'h0F);

    // T5 reset mid-load
    do_reset();
    start_load();
    shift_key(8'hA5);
    apply_data("t5_pre", 8'hFF, 8'h55);
    start_load();
    for (int i = 0; i < 5; i++) begin
      key_valid = 1'b1; key_bit = 8'hA5 >> i;
      step();
    end
    key_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_ready", key_ready, 0);
    check("t5_armed", armed, 0);
    check("t5_data_out", data_out, 0);
    check("t5_data_out_valid", data_out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      key_valid = 1'b1; key_bit = 1'b1; data_in_valid = 1'b1;
      step();
    end
    key_valid = 1'b0; data_in_valid = 1'b0;
    check("t5_idle_armed", armed, 0);
    check("t5_idle_valid", data_out_valid, 0);
    start_load();
    shift_key(8'hA5);
    apply_data("t5_post", 8'h00, 8'hAA);

`ifdef RLL_LOAD_LIMIT_EN
    // T6 load limit
    do_reset();
    start_load();
    shift_key(8'hA5);
    start_load();
    shift_key(8'hA5);
    load_start = 1'b1;
    step();
    check("t6_lockout", lockout, 1);
    check("t6_armed", armed, 0);
    check("t6_ready", key_ready, 0);
    step();
    load_start = 1'b0;
    check("t6_ignored_ready", key_ready, 0);
    check("t6_lockout_held", lockout, 1);
    data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0;
    check("t6_no_data", data_out_valid, 0);
    do_reset();
    check("t6_rst_clears", lockout, 0);
`else
    check("t6_lockout_tied", lockout, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
